// File: rtl/ex_stage_pkg.sv
// Shared CPU definitions for the execute stage: pipeline bus layouts, PCSrc and ALUFun codes.
package ex_stage_pkg;

  localparam int unsigned IdExW  = 158;
  localparam int unsigned ExMemW = 73;

  localparam logic [2:0] PcSrcBranch = 3'b001;

  // ALUFun[5:4] selects the operation class.
  typedef enum logic [1:0] {
    AluArith = 2'b00,
    AluLogic = 2'b01,
    AluShift = 2'b10,
    AluCmp   = 2'b11
  } alu_class_e;

  // Field order fixes the bit positions: rs occupies [157:153] down to data_bus_b at [31:0].
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] lu_out;
    logic        alu_src2;
    logic [31:0] con_ba;
    logic [2:0]  pc_src;
    logic [5:0]  alu_fun;
    logic        sign;
    logic        mem_wr;
    logic        mem_rd;
    logic        reg_wr;
    logic        mem_to_reg;
    logic [4:0]  addr_c;
    logic [31:0] alu_a;
    logic [31:0] data_bus_b;
  } id2ex_t;

  // alu_out occupies [72:41] down to mem_to_reg at [0].
  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [4:0]  addr_c;
    logic        mem_wr;
    logic        mem_rd;
    logic        reg_wr;
    logic        mem_to_reg;
  } ex2mem_t;

endpackage

// File: rtl/ex_stage_if.sv
// Execute-stage bus bundle; master drives the ID/EX and WB side, slave is the execute stage.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [IdExW-1:0]  ID2EX;
  logic [4:0]        WBAddrC;
  logic              WBRegWr;
  logic [31:0]       WBData;
  logic [4:0]        IDRs;
  logic [4:0]        IDRt;
  logic [ExMemW-1:0] EX2MEM;
  logic              Stall;
  logic              Flush;
  logic [31:0]       BranchTarget;

  modport master (
    output ID2EX, WBAddrC, WBRegWr, WBData, IDRs, IDRt,
    input  EX2MEM, Stall, Flush, BranchTarget
  );

  modport slave (
    input  ID2EX, WBAddrC, WBRegWr, WBData, IDRs, IDRt,
    output EX2MEM, Stall, Flush, BranchTarget
  );
endinterface

// File: rtl/ex_stage_alu.sv
// 32-bit ALU: arithmetic, logic, shift (shamt from a[4:0]) and compare classes.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [5:0]  alu_fun_i,
  input  logic        sign_i,
  output logic [31:0] z_o
);

  logic [4:0] shamt;
  logic       lt;
  logic       a_zero;

  assign shamt  = a_i[4:0];
  assign a_zero = (a_i == '0);
  assign lt     = sign_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);

  always_comb begin
    z_o = '0;
    unique case (alu_class_e'(alu_fun_i[5:4]))
      AluArith: z_o = alu_fun_i[0] ? (a_i - b_i) : (a_i + b_i);
      AluLogic: begin
        case (alu_fun_i[3:0])
          4'b1000: z_o = a_i & b_i;
          4'b1110: z_o = a_i | b_i;
          4'b0110: z_o = a_i ^ b_i;
          4'b0001: z_o = ~(a_i | b_i);
          4'b1010: z_o = a_i;
          default: z_o = '0;
        endcase
      end
      AluShift: begin
        case (alu_fun_i[1:0])
          2'b00:   z_o = b_i << shamt;
          2'b01:   z_o = b_i >> shamt;
          2'b11:   z_o = 32'($signed(b_i) >>> shamt);
          default: z_o = '0;
        endcase
      end
      AluCmp: begin
        case (alu_fun_i[3:1])
          3'b001:  z_o[0] = (a_i == b_i);
          3'b000:  z_o[0] = (a_i != b_i);
          3'b010:  z_o[0] = lt;
          3'b110:  z_o[0] = a_i[31] | a_zero;
          3'b101:  z_o[0] = a_i[31];
          3'b111:  z_o[0] = ~a_i[31] & ~a_zero;
          default: z_o[0] = 1'b0;
        endcase
      end
      default: z_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, EX/MEM pipeline register, branch flush and load-use stall.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  ex_stage_if.slave bus
);

  id2ex_t      id;
  ex2mem_t     ex2mem_q, ex2mem_d;
  logic [31:0] op_a, fwd_b, op_b, z;
  logic        is_shift, flush;

  assign id = id2ex_t'(bus.ID2EX);

  // Shifts take shamt from ALUA, so A must never be overwritten by a forwarded value.
  always_comb begin
    is_shift = (alu_class_e'(id.alu_fun[5:4]) == AluShift);
    op_a     = id.alu_a;
    if (id.rs != '0 && !is_shift && ex2mem_q.reg_wr && ex2mem_q.addr_c == id.rs) begin
      op_a = ex2mem_q.alu_out;
    end else if (id.rs != '0 && !is_shift && bus.WBRegWr && bus.WBAddrC == id.rs) begin
      op_a = bus.WBData;
    end
    fwd_b = id.data_bus_b;
    if (id.rt != '0 && ex2mem_q.reg_wr && ex2mem_q.addr_c == id.rt) begin
      fwd_b = ex2mem_q.alu_out;
    end else if (id.rt != '0 && bus.WBRegWr && bus.WBAddrC == id.rt) begin
      fwd_b = bus.WBData;
    end
    op_b = id.alu_src2 ? id.lu_out : fwd_b;
  end

  ex_stage_alu u_alu (
    .a_i       (op_a),
    .b_i       (op_b),
    .alu_fun_i (id.alu_fun),
    .sign_i    (id.sign),
    .z_o       (z)
  );

  always_comb begin
    ex2mem_d            = '0;
    ex2mem_d.alu_out    = z;
    ex2mem_d.write_data = fwd_b;
    ex2mem_d.addr_c     = id.addr_c;
    ex2mem_d.mem_wr     = id.mem_wr;
    ex2mem_d.mem_rd     = id.mem_rd;
    ex2mem_d.reg_wr     = id.reg_wr;
    ex2mem_d.mem_to_reg = id.mem_to_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex2mem_q <= '0;
    end else begin
      ex2mem_q <= ex2mem_d;
    end
  end

  // A taken branch squashes the ID instruction, so a load-use stall on it is moot.
  always_comb begin
    flush            = (id.pc_src == PcSrcBranch) && z[0];
    bus.Flush        = flush;
    bus.Stall        = id.mem_rd && (id.addr_c != '0) &&
                       ((id.addr_c == bus.IDRs) || (id.addr_c == bus.IDRt)) && !flush;
    bus.BranchTarget = id.con_ba;
    bus.EX2MEM       = ex2mem_q;
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios with literal expectations, then random traffic vs a model.
module tb_ex_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [72:0] mq = '0;

  localparam logic [5:0] FAdd = 6'b000000, FSub = 6'b000001, FAnd = 6'b011000;
  localparam logic [5:0] FOr  = 6'b011110, FXor = 6'b010110, FNor = 6'b010001;
  localparam logic [5:0] FA   = 6'b011010, FSll = 6'b100000, FSrl = 6'b100001;
  localparam logic [5:0] FSra = 6'b100011, FEq  = 6'b110011, FNeq = 6'b110001;
  localparam logic [5:0] FLt  = 6'b110101, FLez = 6'b111101, FLtz = 6'b111011;
  localparam logic [5:0] FGtz = 6'b111111;

  logic [5:0] funs [16] = '{FAdd, FSub, FAnd, FOr, FXor, FNor, FA, FSll,
                            FSrl, FSra, FEq, FNeq, FLt, FLez, FLtz, FGtz};

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [157:0] mk_id(logic [4:0] rs, logic [4:0] rt, logic [31:0] lu,
      logic src2, logic [31:0] conba, logic [2:0] pcsrc, logic [5:0] fun, logic sgn,
      logic mw, logic mr, logic rw, logic m2r, logic [4:0] ac, logic [31:0] alua,
      logic [31:0] dbb);
    return {rs, rt, lu, src2, conba, pcsrc, fun, sgn, mw, mr, rw, m2r, ac, alua, dbb};
  endfunction

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [5:0] f,
      logic s);
    int unsigned sh;
    sh = int'(a[4:0]);
    case (f)
      FAdd: return a + b;
      FSub: return a - b;
      FAnd: return a & b;
      FOr:  return a | b;
      FXor: return a ^ b;
      FNor: return ~(a | b);
      FA:   return a;
      FSll: return b << sh;
      FSrl: return b >> sh;
      FSra: return 32'($signed(b) >>> sh);
      FEq:  return (a == b) ? 32'd1 : 32'd0;
      FNeq: return (a != b) ? 32'd1 : 32'd0;
      FLt:  return (s ? ($signed(a) < $signed(b)) : (a < b)) ? 32'd1 : 32'd0;
      FLez: return ($signed(a) <= 0) ? 32'd1 : 32'd0;
      FLtz: return ($signed(a) < 0) ? 32'd1 : 32'd0;
      FGtz: return ($signed(a) > 0) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Reference for one EX cycle, from the current bus inputs and the modelled EX/MEM register.
  task automatic model_eval(output logic [72:0] nxt, output logic stall, output logic flush,
                            output logic [31:0] bt);
    logic [157:0] id;
    logic [4:0]   rs, rt, ac;
    logic [5:0]   fun;
    logic [31:0]  a, fb, b, z;
    logic         shift;
    id    = bus.ID2EX;
    rs    = id[157:153];
    rt    = id[152:148];
    fun   = id[79:74];
    ac    = id[68:64];
    shift = (fun[5:4] == 2'b10);
    a     = id[63:32];
    if (rs != 0 && !shift && mq[1] && mq[8:4] == rs)            a = mq[72:41];
    else if (rs != 0 && !shift && bus.WBRegWr && bus.WBAddrC == rs) a = bus.WBData;
    fb = id[31:0];
    if (rt != 0 && mq[1] && mq[8:4] == rt)                    fb = mq[72:41];
    else if (rt != 0 && bus.WBRegWr && bus.WBAddrC == rt)     fb = bus.WBData;
    b     = id[115] ? id[147:116] : fb;
    z     = ref_alu(a, b, fun, id[73]);
    flush = (id[82:80] == 3'b001) && z[0];
    stall = id[71] && ac != 0 && (ac == bus.IDRs || ac == bus.IDRt) && !flush;
    bt    = id[114:83];
    nxt   = {z, fb, ac, id[72], id[71], id[70], id[69]};
  endtask

  task automatic drive(input logic [157:0] id, input logic [4:0] wa, input logic wrw,
                       input logic [31:0] wd, input logic [4:0] irs, input logic [4:0] irt);
    bus.ID2EX   = id;
    bus.WBAddrC = wa;
    bus.WBRegWr = wrw;
    bus.WBData  = wd;
    bus.IDRs    = irs;
    bus.IDRt    = irt;
  endtask

  function automatic logic [31:0] rnd_val();
    return ($urandom_range(0, 2) == 0) ? $urandom() : 32'($urandom_range(0, 3));
  endfunction

  logic [72:0] nxt;
  logic        m_stall, m_flush;
  logic [31:0] m_bt;

  initial begin
    drive('0, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0);

    // Reference model spot checks.
    chk("model_add", 73'(ref_alu(32'd5, 32'd7, FAdd, 1'b0)), 73'd12);
    chk("model_lt_signed", 73'(ref_alu(32'hffff_ffff, 32'd1, FLt, 1'b1)), 73'd1);
    chk("model_sra", 73'(ref_alu(32'd4, 32'h8000_0000, FSra, 1'b0)), 73'h0_f800_0000);

    #3;
    chk("reset_ex2mem", bus.EX2MEM, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bubble_ex2mem", bus.EX2MEM, '0);
      chk("bubble_stall", 73'(bus.Stall), '0);
      chk("bubble_flush", 73'(bus.Flush), '0);
    end

    // ADD 5+7 -> r8.
    @(negedge clk);
    drive(mk_id(0, 0, 0, 0, 0, 0, FAdd, 0, 0, 0, 1, 0, 5'd8, 32'd5, 32'd7), 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("add_aluout", 73'(bus.EX2MEM[72:41]), 73'd12);
    chk("add_addrc", 73'(bus.EX2MEM[8:4]), 73'd8);
    chk("add_regwr", 73'(bus.EX2MEM[1]), 73'd1);

    // Dependent ADDI on r8 with stale ALUA; WB also claims r8 but EX/MEM wins.
    @(negedge clk);
    drive(mk_id(5'd8, 0, 32'd3, 1, 0, 0, FAdd, 0, 0, 0, 1, 0, 5'd9, 32'd0, 32'd0),
          5'd8, 1, 32'd99, 0, 0);
    @(posedge clk); #1;
    chk("fwd_ex_over_wb", 73'(bus.EX2MEM[72:41]), 73'd15);

    // Load-use against IDRt, then no match.
    @(negedge clk);
    drive(mk_id(0, 0, 0, 0, 0, 0, FAdd, 0, 0, 1, 1, 1, 5'd9, 0, 0), 0, 0, 0, 5'd0, 5'd9);
    #1;
    chk("load_use_stall", 73'(bus.Stall), 73'd1);
    bus.IDRt = 5'd0;
    #1;
    chk("load_use_nomatch", 73'(bus.Stall), 73'd0);

    // r0 never forwarded from WB.
    @(negedge clk);
    drive(mk_id(0, 0, 0, 0, 0, 0, FAdd, 0, 0, 0, 1, 0, 5'd3, 32'd1, 32'd0), 5'd0, 1, 32'd5,
          0, 0);
    @(posedge clk); #1;
    chk("r0_no_fwd", 73'(bus.EX2MEM[72:41]), 73'd1);

    // Taken BEQ with a simultaneous load-use match: flush wins.
    @(negedge clk);
    drive(mk_id(0, 0, 0, 0, 32'h0040_0040, 3'b001, FEq, 0, 0, 1, 0, 0, 5'd9, 32'd5, 32'd5),
          0, 0, 0, 5'd9, 0);
    #1;
    chk("branch_flush", 73'(bus.Flush), 73'd1);
    chk("branch_target", 73'(bus.BranchTarget), 73'h0040_0040);
    chk("flush_over_stall", 73'(bus.Stall), 73'd0);
    bus.ID2EX = mk_id(0, 0, 0, 0, 32'h0040_0040, 3'b001, FEq, 0, 0, 1, 0, 0, 5'd9, 32'd5,
                      32'd6);
    #1;
    chk("branch_not_taken", 73'(bus.Flush), 73'd0);
    chk("stall_when_no_flush", 73'(bus.Stall), 73'd1);
    @(posedge clk); #1;
    chk("branch_propagates", 73'(bus.EX2MEM[8:1]), 73'b01001_010);

    // Shift with Rs matching EX/MEM and WB: shamt stays ALUA.
    @(negedge clk);
    drive(mk_id(0, 0, 0, 0, 0, 0, FAdd, 0, 0, 0, 1, 0, 5'd4, 32'd3, 32'd0), 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(mk_id(5'd4, 0, 0, 0, 0, 0, FSll, 0, 0, 0, 1, 0, 5'd5, 32'd4, 32'd1), 5'd4, 1,
          32'd2, 0, 0);
    @(posedge clk); #1;
    chk("shift_no_fwd", 73'(bus.EX2MEM[72:41]), 73'd16);

    // Asynchronous reset mid-cycle discards the in-flight result.
    @(negedge clk);
    drive('0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_clear", bus.EX2MEM, '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("after_release", bus.EX2MEM, '0);

    mq = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        drive('0, 5'($urandom_range(0, 3)), 1'($urandom), $urandom(),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end else begin
        drive(mk_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), rnd_val(),
                    1'($urandom), $urandom(), 3'($urandom_range(0, 2)),
                    funs[$urandom_range(0, 15)], 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), rnd_val(),
                    rnd_val()),
              5'($urandom_range(0, 3)), 1'($urandom), rnd_val(),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end
      #1;
      model_eval(nxt, m_stall, m_flush, m_bt);
      chk("rand_ex2mem", bus.EX2MEM, mq);
      chk("rand_stall", 73'(bus.Stall), 73'(m_stall));
      chk("rand_flush", 73'(bus.Flush), 73'(m_flush));
      chk("rand_target", 73'(bus.BranchTarget), 73'(m_bt));
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b0;
        #1;
        chk("rand_async_reset", bus.EX2MEM, '0);
        mq = '0;
        @(posedge clk);
      end else begin
        @(posedge clk);
        mq = nxt;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk input 1 clock; reset input 1 asynchronous active-low reset.
REQ-002 SHALL have ID2EX input 158, packed ID/EX bus: Rs[157:153], Rt[152:148], LUout[147:116], ALUSrc2[115], ConBA[114:83], PCSrc[82:80], ALUFun[79:74], Sign[73], MemWr[72], MemRd[71], RegWr[70], MemToReg[69], AddrC[68:64], ALUA[63:32], DataBusB[31:0].
REQ-003 SHALL have WBAddrC input 5, WBRegWr input 1, WBData input 32: write-back stage destination, write enable and data.
REQ-004 SHALL have IDRs input 5, IDRt input 5: source registers of the instruction currently in ID.
REQ-005 SHALL have EX2MEM output 73, registered: ALUOut[72:41], WriteData[40:9], AddrC[8:4], MemWr[3], MemRd[2], RegWr[1], MemToReg[0].
REQ-006 SHALL have Stall output 1, Flush output 1, BranchTarget output 32, all combinational.

Function
REQ-007 SHALL unpack ID2EX into named fields per REQ-002; an all-zero bus is a bubble and SHALL produce no register or memory write.
REQ-008 Forward A: if Rs!=0 and ALUFun[5:4]!=2'b10 (non-shift) and EX2MEM.RegWr and EX2MEM.AddrC==Rs, A = EX2MEM.ALUOut; else if Rs!=0, WBRegWr, WBAddrC==Rs, and not shift class, A = WBData; else A = ALUA.
REQ-009 Forward B: same priority (EX2MEM first, then WB) on Rt with Rt!=0, replacing DataBusB; the result is FwdB.
REQ-010 ALU operand B SHALL be LUout when ALUSrc2=1, else FwdB; WriteData SHALL be FwdB regardless of ALUSrc2.
REQ-011 SHALL compute Z = alu(A, B, ALUFun, Sign) combinationally, 32-bit, with ALUFun encoding per the team ALU (6'b000000 ADD, 6'b000001 SUB).
REQ-012 On each rising clk, EX2MEM SHALL load {Z, FwdB, AddrC, MemWr, MemRd, RegWr, MemToReg}; one-cycle latency ID2EX -> EX2MEM.
REQ-013 Branch: Flush = (PCSrc==3'b001) && Z[0]; BranchTarget = ConBA at all times.
REQ-014 Load-use: Stall = EX MemRd && AddrC!=0 && (AddrC==IDRs || AddrC==IDRt) && !Flush.
REQ-015 Flush has priority over Stall when both conditions hold in the same cycle.
REQ-016 A WB write to register 0 SHALL never be forwarded; register 0 reads as ALUA/DataBusB.
REQ-017 When EX2MEM and WB both match the same source, the EX2MEM (younger) value SHALL win.
REQ-018 The branch instruction itself SHALL still propagate into EX2MEM (RegWr=0 as decoded); this block does not clear its own stage on Flush.

Reset
REQ-019 reset low SHALL asynchronously clear EX2MEM to 73'b0; Stall/Flush then depend only on ID2EX.
REQ-020 Reset asserted mid-operation SHALL discard the in-flight EX2MEM contents; no partial write SHALL appear after release.

Structure
REQ-021 ID2EX and EX2MEM field bit positions and widths, the PCSrc branch code 3'b001, and the ALUFun shift class 2'b10 SHALL be named constants in the shared CPU package.
REQ-022 SHALL instantiate the existing alu sub-module; forwarding muxes and hazard logic stay in ex_stage.

Verification
REQ-023 Reset low -> EX2MEM==0; release, bubble ID2EX=0 for 3 cycles -> EX2MEM stays 0, Stall=0, Flush=0.
REQ-024 ADD, ALUA=5, DataBusB=7, ALUSrc2=0, AddrC=8, RegWr=1 -> next cycle ALUOut=12, AddrC=8, RegWr=1.
REQ-025 Back-to-back: instr1 writes r8=12; instr2 Rs=8, ALUA=0 (stale), LUout=3, ALUSrc2=1, ADD -> ALUOut=15 (EX2MEM forward); with WBAddrC=8, WBData=99 also matching, 15 SHALL still result.
REQ-026 Load in EX (MemRd=1, AddrC=9), IDRt=9 -> Stall=1; IDRs=IDRt=0 -> Stall=0; Rs=0 with WBRegWr=1, WBAddrC=0, WBData=5 -> no forward.
REQ-027 Branch PCSrc=3'b001, ALU compare result Z=1, ConBA=0x00400040 -> Flush=1, BranchTarget=0x00400040; same cycle load-use match -> Stall=0.
REQ-028 Shift ALUFun[5:4]=2'b10, ALUA=4 (shamt), Rs matching EX2MEM.AddrC -> A stays 4, no forwarding.
